// File: rtl/serial_byte_collector.sv
// Serial-to-parallel word collector: shifts in one bit per accepted transfer,
// buffers completed words in a small FIFO and presents them on a valid/ready port.
module serial_byte_collector #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       word_count
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [PW:0]   FULL_OCC = (PW + 1)'(DEPTH);

  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      occ_r;
  logic [WIDTH-1:0] out_r;
  logic             out_valid_r;
  logic [7:0]       word_count_r;

  logic [CW-1:0]    pos_s;
  logic [WIDTH-1:0] word_s;
  logic             full_s;
  logic             pop_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             complete_s;
  logic             push_s;
  logic [CW-1:0]    cnt_next_s;
  logic [WIDTH-1:0] shift_next_s;
  logic [PW-1:0]    wr_ptr_next_s;
  logic [PW-1:0]    rd_ptr_next_s;
  logic [PW:0]      occ_next_s;
  logic [WIDTH-1:0] head_next_s;

  // Word assembly: the current bit merged into the partial word; gated so an idle in0 never leaks in.
  always_comb begin
    pos_s  = cnt_r;
    word_s = shift_r;
    if (LSB_FIRST != 0) begin
      pos_s = cnt_r;
    end else begin
      pos_s = LAST_BIT - cnt_r;
    end
    word_s[pos_s] = in0 & in_valid;
  end

  // Handshake decode; only the completing bit can stall, and a same-cycle pop frees the slot.
  always_comb begin
    full_s     = (occ_r == FULL_OCC);
    pop_s      = out_valid_r & out_ready;
    in_ready_s = (cnt_r != LAST_BIT) | ~full_s | pop_s;
    accept_s   = in_valid & in_ready_s;
    complete_s = accept_s & (cnt_r == LAST_BIT);
    push_s     = complete_s & ~clear;
  end

  // Next-state for the collector, FIFO pointers and the registered head word.
  always_comb begin
    cnt_next_s    = cnt_r;
    shift_next_s  = shift_r;
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    occ_next_s    = occ_r;
    head_next_s   = {WIDTH{1'b0}};

    if (clear || complete_s) begin
      cnt_next_s   = {CW{1'b0}};
      shift_next_s = {WIDTH{1'b0}};
    end else if (accept_s) begin
      cnt_next_s   = cnt_r + CW'(1);
      shift_next_s = word_s;
    end else begin
      cnt_next_s   = cnt_r;
      shift_next_s = shift_r;
    end

    if (push_s) begin
      wr_ptr_next_s = wr_ptr_r + PW'(1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PW'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + (PW + 1)'(1);
      2'b01:   occ_next_s = occ_r - (PW + 1)'(1);
      default: occ_next_s = occ_r;
    endcase

    // The slot being written is the new head only when it is the sole entry left.
    if (occ_next_s == {(PW + 1){1'b0}}) begin
      head_next_s = {WIDTH{1'b0}};
    end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
      head_next_s = word_s;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= {CW{1'b0}};
      shift_r      <= {WIDTH{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      rd_ptr_r     <= {PW{1'b0}};
      occ_r        <= {(PW + 1){1'b0}};
      out_r        <= {WIDTH{1'b0}};
      out_valid_r  <= 1'b0;
      word_count_r <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      cnt_r       <= cnt_next_s;
      shift_r     <= shift_next_s;
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      occ_r       <= occ_next_s;
      out_r       <= head_next_s;
      out_valid_r <= (occ_next_s != {(PW + 1){1'b0}});
      if (push_s) begin
        mem_r[wr_ptr_r] <= word_s;
        word_count_r    <= word_count_r + 8'd1;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out        = out_r;
  assign out_valid  = out_valid_r;
  assign word_count = word_count_r;

endmodule

// File: tb/tb_serial_byte_collector.sv
// Randomized self-checking bench for serial_byte_collector; runs an LSB-first and an
// MSB-first instance side by side against a queue-based reference model.
module tb_serial_byte_collector;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk;
  logic         rst;
  logic         clear;
  logic         in0;
  logic         in_valid;
  logic         out_ready;
  logic         in_ready;
  logic         in_ready_m;
  logic [W-1:0] out;
  logic [W-1:0] out_m;
  logic         out_valid;
  logic         out_valid_m;
  logic [7:0]   word_count;
  logic [7:0]   word_count_m;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  logic         bits_q[$];
  logic [W-1:0] lsb_q[$];
  logic [W-1:0] msb_q[$];
  int           wcnt;
  logic         exp_ready;
  logic         act_ready;

  serial_byte_collector #(.WIDTH(W), .DEPTH(D), .LSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in0(in0), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .word_count(word_count)
  );

  serial_byte_collector #(.WIDTH(W), .DEPTH(D), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .clear(clear), .in0(in0), .in_valid(in_valid),
    .in_ready(in_ready_m), .out(out_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .word_count(word_count_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_out();
    return (lsb_q.size() > 0) ? lsb_q[0] : 8'h00;
  endfunction

  function automatic logic [W-1:0] m_out_m();
    return (msb_q.size() > 0) ? msb_q[0] : 8'h00;
  endfunction

  function automatic logic m_valid();
    return lsb_q.size() > 0;
  endfunction

  task automatic model_reset();
    bits_q.delete();
    lsb_q.delete();
    msb_q.delete();
    wcnt = 0;
  endtask

  // One clock: drive, sample in_ready at the falling edge, step the model at the rising edge.
  task automatic cycle(input logic v, input logic b, input logic r, input logic c);
    logic [W-1:0] wl;
    logic [W-1:0] wm;
    logic         pop;
    in_valid  = v;
    in0       = v ? b : 1'bx;
    out_ready = r;
    clear     = c;
    @(negedge clk);
    exp_ready = (bits_q.size() != W - 1) || (lsb_q.size() < D) || (lsb_q.size() > 0 && r);
    act_ready = in_ready;
    @(posedge clk);
    pop = (lsb_q.size() > 0) && r;
    if (pop) begin
      void'(lsb_q.pop_front());
      void'(msb_q.pop_front());
    end
    if (c) begin
      bits_q.delete();
    end else if (v && exp_ready) begin
      bits_q.push_back(b);
      if (bits_q.size() == W) begin
        wl = '0;
        wm = '0;
        for (int k = 0; k < W; k++) begin
          wl[k]       = bits_q[k];
          wm[W-1-k]   = bits_q[k];
        end
        lsb_q.push_back(wl);
        msb_q.push_back(wm);
        wcnt = (wcnt + 1) % 256;
        bits_q.delete();
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    in0 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    in0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out !== 8'h00 || word_count !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b out=%h wc=%h, want 0/00/00", out_valid, out, word_count);
    end
    rst = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_pattern();
    logic [7:0] pat;
    pat = 8'b0100_1101;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, pat[k], 1'b1, 1'b0);
      if (k < 7) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL pattern_early_valid: bit %0d got %b want 0", k, out_valid);
        end
      end
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out !== 8'h4D || out !== m_out() || word_count !== 8'd1) begin
      n_fail++;
      $display("FAIL pattern_lsb: got valid=%b out=%h wc=%0d want 1/4d/1", out_valid, out, word_count);
    end
    n_cmp++;
    if (out_valid_m !== 1'b1 || out_m !== 8'hB2 || out_m !== m_out_m()) begin
      n_fail++;
      $display("FAIL pattern_msb: got valid=%b out=%h want 1/b2", out_valid_m, out_m);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || out !== 8'h00) begin
      n_fail++;
      $display("FAIL pattern_one_cycle: got valid=%b out=%h want 0/00", out_valid, out);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] stream;
    logic [7:0]  third;
    third  = 8'($urandom);
    stream = {third, 8'h3C, 8'hA5};
    do_reset();
    for (int k = 0; k < 24; k++) begin
      cycle(1'b1, stream[k], 1'b0, 1'b0);
      n_cmp++;
      if (act_ready !== exp_ready || act_ready !== (k != 23)) begin
        n_fail++;
        $display("FAIL bp_in_ready: bit %0d got %b want %b", k, act_ready, (k != 23));
      end
    end
    repeat (3) cycle(1'b1, stream[23], 1'b0, 1'b0);
    n_cmp++;
    if (act_ready !== 1'b0 || out !== 8'hA5 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: got ready=%b out=%h valid=%b want 0/a5/1", act_ready, out, out_valid);
    end
    // completing bit presented with a same-cycle pop on a full FIFO
    cycle(1'b1, stream[23], 1'b1, 1'b0);
    n_cmp++;
    if (act_ready !== 1'b1 || out !== 8'h3C || out_valid !== 1'b1 || word_count !== 8'd3) begin
      n_fail++;
      $display("FAIL bp_full_pushpop: got ready=%b out=%h valid=%b wc=%0d want 1/3c/1/3",
               act_ready, out, out_valid, word_count);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (out !== third || out !== m_out() || out_valid !== 1'b1 || out_m !== m_out_m()) begin
      n_fail++;
      $display("FAIL bp_drain_third: got out=%h valid=%b want %h/1", out, out_valid, third);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || out !== 8'h00 || word_count !== 8'd3) begin
      n_fail++;
      $display("FAIL bp_drain_empty: got valid=%b out=%h wc=%0d want 0/00/3", out_valid, out, word_count);
    end
  endtask

  task automatic test_clear();
    int nvalid;
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'($urandom), 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    nvalid = 0;
    for (int k = 0; k < 10; k++) begin
      cycle((k < 8), 1'b1, 1'b1, 1'b0);
      if (out_valid === 1'b1) begin
        nvalid++;
        n_cmp++;
        if (out !== 8'hFF || out_m !== 8'hFF) begin
          n_fail++;
          $display("FAIL clear_word: got %h/%h want ff/ff", out, out_m);
        end
      end
    end
    n_cmp++;
    if (nvalid != 1 || word_count !== 8'd1) begin
      n_fail++;
      $display("FAIL clear_count: got %0d words wc=%0d want 1/1", nvalid, word_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 19; k++) cycle(1'b1, 1'($urandom), 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out !== m_out() || word_count !== 8'd2) begin
      n_fail++;
      $display("FAIL areset_pre: got valid=%b out=%h wc=%0d want 1/%h/2", out_valid, out, word_count, m_out());
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out !== 8'h00 || word_count !== 8'h00 || out_m !== 8'h00) begin
      n_fail++;
      $display("FAIL areset_immediate: got valid=%b out=%h wc=%h want 0/00/00", out_valid, out, word_count);
    end
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'($urandom), 1'b1, 1'b0);
      n_cmp++;
      if (out_valid !== (k == 7) || out !== m_out() || out_m !== m_out_m()) begin
        n_fail++;
        $display("FAIL areset_fresh: bit %0d got valid=%b out=%h want %b/%h", k, out_valid, out, (k == 7), m_out());
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int w = 0; w < 256; w++) begin
      for (int k = 0; k < 8; k++) cycle(1'b1, 1'($urandom), 1'b1, 1'b0);
      if (w == 254) begin
        n_cmp++;
        if (word_count !== 8'd255 || word_count_m !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_255: got %0d want 255", word_count);
        end
      end
    end
    n_cmp++;
    if (word_count !== 8'd0 || word_count !== wcnt[7:0]) begin
      n_fail++;
      $display("FAIL wrap_zero: got %0d want 0", word_count);
    end
  endtask

  task automatic test_random();
    int thr;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      thr = ((n / 300) % 2 == 0) ? 25 : 90;
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 99) < thr),
            ($urandom_range(0, 39) == 0));
      n_cmp++;
      if (act_ready !== exp_ready || out_valid !== m_valid() || out !== m_out() ||
          out_m !== m_out_m() || word_count !== wcnt[7:0]) begin
        n_fail++;
        $display("FAIL random: cycle %0d got ready=%b valid=%b out=%h outm=%h wc=%0d want %b/%b/%h/%h/%0d",
                 n, act_ready, out_valid, out, out_m, word_count,
                 exp_ready, m_valid(), m_out(), m_out_m(), wcnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    in0 = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_pattern();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
